// File: rtl/wb_arb_pkg.sv
// ---------------------------------------------------------------------------
// wb_arb_pkg
// Shared types and constants for the two-master Wishbone round-robin arbiter.
//   arb_state_e      : arbiter FSM state (IDLE / BUSY / TERM)
//   G_NONE/G_M0/G_M1 : one-hot grant encodings as seen on grant_o
//   LAST_M0/LAST_M1  : encoding of the "last served master" bit
//   ERR_DATA_DEFAULT : read data handed back when a slave access times out
// ---------------------------------------------------------------------------
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TERM = 2'd2
  } arb_state_e;

  localparam logic [1:0] G_NONE = 2'b00;
  localparam logic [1:0] G_M0   = 2'b01;
  localparam logic [1:0] G_M1   = 2'b10;

  localparam logic LAST_M0 = 1'b0;
  localparam logic LAST_M1 = 1'b1;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_rr_pick.sv
// ---------------------------------------------------------------------------
// wb_rr_pick
// Pure combinational two-way round-robin picker.
// Ports:
//   req_i  [1:0] : request vector, bit 0 = m0, bit 1 = m1
//   last_i       : master served most recently (LAST_M0 / LAST_M1)
//   gnt_o  [1:0] : one-hot pick, G_NONE when nobody requests
// ---------------------------------------------------------------------------
module wb_rr_pick
  import wb_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  // On a tie the master that was not served last wins, giving strict
  // alternation under sustained contention.
  always_comb begin
    gnt_o = G_NONE;
    case (req_i)
      2'b01:   gnt_o = G_M0;
      2'b10:   gnt_o = G_M1;
      2'b11:   gnt_o = (last_i == LAST_M1) ? G_M0 : G_M1;
      default: gnt_o = G_NONE;
    endcase
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter
// Two-master, one-slave Wishbone arbiter. The management SoC (m0) and a user
// DMA/sequencer (m1) share the user slave bus. One transaction per grant,
// round-robin between masters, and a slave-hang timeout that terminates the
// access with an error-data acknowledge.
// Ports:
//   wb_clk_i, wb_rst_i          : clock, synchronous active-high reset
//   m0_* / m1_* (inputs)        : cyc, stb, we, sel, adr, dat from each master
//   m0_ack_o/m0_dat_o, m1_*     : acknowledge and read data back to masters
//   s_cyc_o ... s_dat_o         : muxed request towards the slave decoder
//   s_ack_i, s_dat_i            : slave acknowledge and read data
//   grant_o                     : one-hot current grant, 00 when idle
//   timeout_o                   : one-cycle pulse on a forced termination
// ---------------------------------------------------------------------------
module wb_rr_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [DW-1:0] ERR_DATA = DW'(wb_arb_pkg::ERR_DATA_DEFAULT)
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,

  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [3:0]    m0_sel_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  output logic          m0_ack_o,
  output logic [DW-1:0] m0_dat_o,

  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [3:0]    m1_sel_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  output logic          m1_ack_o,
  output logic [DW-1:0] m1_dat_o,

  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [3:0]    s_sel_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  input  logic          s_ack_i,
  input  logic [DW-1:0] s_dat_i,

  output logic [1:0]    grant_o,
  output logic          timeout_o
);

  import wb_arb_pkg::*;

  localparam int unsigned   CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TERM_CNT = CW'(TIMEOUT - 1);

  arb_state_e    state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          last_q,  last_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  logic [1:0]    req;
  logic [1:0]    pick_gnt;

  logic          g_cyc;
  logic          g_stb;
  logic          g_we;
  logic [3:0]    g_sel;
  logic [AW-1:0] g_adr;
  logic [DW-1:0] g_dat;

  assign req[0] = m0_cyc_i & m0_stb_i;
  assign req[1] = m1_cyc_i & m1_stb_i;

  wb_rr_pick u_pick (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (pick_gnt)
  );

  // View of the currently granted master. Outside BUSY/TERM the result is
  // never used, so m0 is simply the fallback selection.
  always_comb begin
    if (grant_q == G_M1) begin
      g_cyc = m1_cyc_i;
      g_stb = m1_stb_i;
      g_we  = m1_we_i;
      g_sel = m1_sel_i;
      g_adr = m1_adr_i;
      g_dat = m1_dat_i;
    end else begin
      g_cyc = m0_cyc_i;
      g_stb = m0_stb_i;
      g_we  = m0_we_i;
      g_sel = m0_sel_i;
      g_adr = m0_adr_i;
      g_dat = m0_dat_i;
    end
  end

  // State register. last_q resets to m1 so that m0 wins the first tie.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      grant_q <= G_NONE;
      last_q  <= LAST_M1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. In BUSY an abort (granted master drops cyc) takes
  // precedence, then a slave ack, and only then the timeout; this makes an
  // ack on the terminal count cycle complete normally.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|req) begin
          state_d = BUSY;
          grant_d = pick_gnt;
        end
      end
      BUSY: begin
        if (!g_cyc || s_ack_i) begin
          state_d = IDLE;
          grant_d = G_NONE;
          last_d  = grant_q[1];
          cnt_d   = '0;
        end else if (cnt_q == TERM_CNT) begin
          state_d = TERM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TERM: begin
        state_d = IDLE;
        grant_d = G_NONE;
        last_d  = grant_q[1];
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = G_NONE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic. The slave bus is only driven in BUSY; everywhere else it
  // is held at zero so idle waveforms stay clean. The ack is gated with the
  // granted cyc so an aborted access never sees a stray acknowledge.
  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_sel_o   = '0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    m0_ack_o  = 1'b0;
    m0_dat_o  = '0;
    m1_ack_o  = 1'b0;
    m1_dat_o  = '0;
    timeout_o = 1'b0;
    case (state_q)
      BUSY: begin
        s_cyc_o = g_cyc;
        s_stb_o = g_cyc & g_stb;
        s_we_o  = g_we;
        s_sel_o = g_sel;
        s_adr_o = g_adr;
        s_dat_o = g_dat;
        if (grant_q[0]) begin
          m0_ack_o = s_ack_i & g_cyc;
          m0_dat_o = s_dat_i;
        end
        if (grant_q[1]) begin
          m1_ack_o = s_ack_i & g_cyc;
          m1_dat_o = s_dat_i;
        end
      end
      TERM: begin
        timeout_o = 1'b1;
        if (grant_q[0]) begin
          m0_ack_o = 1'b1;
          m0_dat_o = ERR_DATA;
        end
        if (grant_q[1]) begin
          m1_ack_o = 1'b1;
          m1_dat_o = ERR_DATA;
        end
      end
      default: begin
      end
    endcase
  end

  assign grant_o = grant_q;

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter in the user project area.
- Lets the management SoC (m0) and a user DMA/sequencer master (m1) share the decoded user slave bus: exmem_fir, wb2axi MM and wb2axi FIR.
- Round-robin grant, one transaction per grant, slave-hang timeout with error termination.
- Sits between the masters and the user address decoder; the decoder is unchanged.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, cycles in BUSY without s_ack_i before forced termination (1..65535)
- ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous reset, active-high
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 Wishbone control
- m0_sel_i  in  4  master 0 byte select
- m0_adr_i  in  AW  master 0 address
- m0_dat_i  in  DW  master 0 write data
- m0_ack_o  out  1  master 0 acknowledge
- m0_dat_o  out  DW  master 0 read data
- m1_*  same set as m0_*  master 1
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave control
- s_sel_o  out  4  slave byte select
- s_adr_o  out  AW  slave address
- s_dat_o  out  DW  slave write data
- s_ack_i  in  1  slave acknowledge
- s_dat_i  in  DW  slave read data
- grant_o  out  2  one-hot current grant; 00 = idle
- timeout_o  out  1  one-cycle pulse on forced termination

Behaviour:
- Clock and reset: one clock, wb_clk_i. wb_rst_i is synchronous, active-high.
- Reset values: state=IDLE, grant_o=00, last=m1 (so m0 wins the first tie), counter=0. All m*_ack_o, s_*_o, timeout_o = 0; m*_dat_o = 0.
- Request: req_n = mn_cyc_i & mn_stb_i.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that master.
  - Both requesting: grant the master that is not `last`.
  - Grant is registered, so arbitration latency is 1 cycle. The slave sees cyc/stb the cycle after the request is first seen in IDLE.
- BUSY:
  - Slave outputs mux combinationally from the granted master's inputs.
  - The non-granted master sees ack=0 and dat=0, and waits.
  - granted m_ack_o = s_ack_i, combinational. granted m_dat_o = s_dat_i.
  - On s_ack_i: next state IDLE, grant cleared, `last` = granted master, counter cleared.
  - One transaction per grant, no bursts. A master that holds cyc/stb after its ack re-arbitrates in IDLE. Result: strict alternation under contention, and each transaction costs a minimum of 2 cycles.
- Abort: the granted master drops cyc_i before ack.
  - Slave cyc/stb deasserted the same cycle (combinational gating).
  - Next state IDLE. `last` is updated. No ack is produced.
- Timeout:
  - Counter increments every BUSY cycle without s_ack_i.
  - When counter == TIMEOUT-1 and s_ack_i=0, go to TERM.
- TERM (1 cycle):
  - s_cyc_o = s_stb_o = 0.
  - Granted m_ack_o = 1, m_dat_o = ERR_DATA.
  - timeout_o = 1.
  - Then IDLE, `last` updated.
- Slave ack in IDLE or TERM: ignored, never forwarded to any master.
- Simultaneous s_ack_i and counter terminal in the same cycle: ack wins, normal completion, no timeout_o.
- Counter width: clog2(TIMEOUT+1). Saturating is not needed because TERM always follows.
- Reset asserted mid-transaction: all outputs go to reset values on the next edge. The pending transaction is dropped silently.
- Outputs while grant_o=00: s_*_o are all zero (address and data included, for deterministic waveforms).

Decomposition:
- Package wb_arb_pkg: state enum {IDLE, BUSY, TERM}, ERR_DATA default, grant encoding constants G_NONE=2'b00, G_M0=2'b01, G_M1=2'b10.
- Sub-module wb_rr_pick: pure combinational 2-way round-robin picker. Inputs: req[1:0], last. Output: one-hot gnt.
- Top module: FSM, counter, muxes.

Test Plan:
- Single m0 write (adr 3800_0010, dat 0000_00A5), slave acks 2 cycles after s_stb_o -> s_stb_o rises 1 cycle after request; m0_ack_o pulses 1 cycle; grant_o 01 then 00.
- m0 and m1 read requests asserted in the same cycle after reset, each held for 3 back-to-back transactions -> grant order m0,m1,m0,m1,m0,m1; each master gets exactly 3 acks; no ack ever reaches the non-granted master.
- m1 read of 3010_0000, slave never acks, TIMEOUT=8 -> 8 BUSY cycles, then m1_ack_o=1 with m1_dat_o=DEAD_BEEF and timeout_o=1 for one cycle; next m0 request is served normally.
- s_ack_i asserted exactly on the terminal count cycle -> normal ack with s_dat_i; timeout_o stays 0.
- m0 drops cyc 1 cycle into BUSY -> s_cyc_o falls the same cycle; no m0_ack_o; a pending m1 is granted next.
- wb_rst_i pulsed for 1 cycle mid-BUSY -> all outputs 0 after the edge; after release, a tie grants m0 first.
